// File: rtl/bitsim_pkg.sv
// Shared width helpers and lane-bundle type for the bit-serial shift-accumulator.
package bitsim_pkg;

  localparam int unsigned DefDataWidth = 8;
  localparam int unsigned DefNumLane   = 8;

  // Each term is data_width+1 bits; summing num_lane of them grows by log2(num_lane).
  function automatic int unsigned sum_width(input int unsigned data_width,
                                            input int unsigned num_lane);
    return data_width + 1 + $clog2(num_lane);
  endfunction

  function automatic int unsigned acc_width(input int unsigned data_width,
                                            input int unsigned num_lane,
                                            input int unsigned weight_bits);
    return sum_width(data_width, num_lane) + weight_bits;
  endfunction

  // Lane i sits at bits [i*(DefDataWidth+1) +: DefDataWidth+1].
  typedef logic [DefNumLane-1:0][DefDataWidth:0] lane_bundle_t;

endpackage

// File: rtl/signed_adder_tree.sv
// Combinational signed adder tree over NUM_LANE two's-complement terms.
module signed_adder_tree
  import bitsim_pkg::*;
#(
  parameter int unsigned  NUM_LANE  = 8,
  parameter int unsigned  IN_WIDTH  = 9,
  localparam int unsigned OUT_WIDTH = sum_width(IN_WIDTH - 1, NUM_LANE)
) (
  input  logic        [NUM_LANE*IN_WIDTH-1:0] terms,
  output logic signed [OUT_WIDTH-1:0]         sum
);

  // Heap-ordered tree: leaves at [NUM_LANE-1 .. 2*NUM_LANE-2], root at 0.
  logic signed [OUT_WIDTH-1:0] node [2*NUM_LANE-1];

  always_comb begin
    for (int i = 0; i < 2 * NUM_LANE - 1; i++) begin
      node[i] = '0;
    end
    for (int i = 0; i < NUM_LANE; i++) begin
      node[NUM_LANE-1+i] = OUT_WIDTH'($signed(terms[i*IN_WIDTH +: IN_WIDTH]));
    end
    for (int i = NUM_LANE - 2; i >= 0; i--) begin
      node[i] = node[2*i+1] + node[2*i+2];
    end
    sum = node[0];
  end

endmodule

// File: rtl/bitserial_shift_acc.sv
// Bit-serial shift-accumulator: registered lane sum, MSB-first fold, valid/ready result register.
module bitserial_shift_acc
  import bitsim_pkg::*;
#(
  parameter int unsigned  DATA_WIDTH  = 8,
  parameter int unsigned  NUM_LANE    = 8,
  parameter int unsigned  WEIGHT_BITS = 7,
  localparam int unsigned SUM_WIDTH   = sum_width(DATA_WIDTH, NUM_LANE),
  localparam int unsigned ACC_WIDTH   = acc_width(DATA_WIDTH, NUM_LANE, WEIGHT_BITS)
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [NUM_LANE*(DATA_WIDTH+1)-1:0]     in_terms,
  input  logic                                   in_last,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic signed [ACC_WIDTH-1:0]            out_data,
  output logic                                   out_err
);

  localparam int unsigned      BeatWidth = (WEIGHT_BITS > 1) ? $clog2(WEIGHT_BITS) : 1;
  localparam logic [BeatWidth-1:0] LastBeat = BeatWidth'(WEIGHT_BITS - 1);

  logic                        enable;
  logic                        accept;
  logic                        closing;
  logic signed [SUM_WIDTH-1:0] tree_sum;

  logic [BeatWidth-1:0]        beat_cnt_q;
  logic                        s1_valid_q;
  logic                        s1_last_q;
  logic [BeatWidth-1:0]        s1_beat_q;
  logic signed [SUM_WIDTH-1:0] s1_sum_q;

  logic signed [ACC_WIDTH-1:0] acc_q;
  logic signed [ACC_WIDTH-1:0] acc_d;
  logic                        s2_close;
  logic                        s2_err;

  // A pending result that downstream refuses freezes the whole pipe.
  assign enable   = !(out_valid && !out_ready);
  assign in_ready = enable;
  assign accept   = in_valid && enable;
  assign closing  = in_last || (beat_cnt_q == LastBeat);

  signed_adder_tree #(
    .NUM_LANE (NUM_LANE),
    .IN_WIDTH (DATA_WIDTH + 1)
  ) u_tree (
    .terms (in_terms),
    .sum   (tree_sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_q <= '0;
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_beat_q  <= '0;
      s1_sum_q   <= '0;
    end else if (enable) begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_sum_q   <= tree_sum;
        s1_last_q  <= in_last;
        s1_beat_q  <= beat_cnt_q;
        beat_cnt_q <= closing ? '0 : beat_cnt_q + 1'b1;
      end
    end
  end

  // Forced close only counts as an error when in_last was not also present.
  always_comb begin
    s2_close = s1_last_q || (s1_beat_q == LastBeat);
    s2_err   = !s1_last_q && (s1_beat_q == LastBeat);
    acc_d    = ACC_WIDTH'(s1_sum_q);
    if (s1_beat_q != '0) begin
      acc_d = (acc_q <<< 1) + ACC_WIDTH'(s1_sum_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_err   <= 1'b0;
    end else if (enable) begin
      out_valid <= s1_valid_q && s2_close;
      if (s1_valid_q) begin
        acc_q <= acc_d;
        if (s2_close) begin
          out_data <= acc_d;
          out_err  <= s2_err;
        end
      end
    end
  end

endmodule

// File: tb/tb_bitserial_shift_acc.sv
// Self-checking bench: directed vector table, hand sequences and randomized scoreboard run.
module tb_bitserial_shift_acc;
  import bitsim_pkg::*;

  localparam int unsigned DW = 8;
  localparam int unsigned NL = 8;
  localparam int unsigned WB = 7;
  localparam int unsigned AW = acc_width(DW, NL, WB);

  logic                 clk;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_ready;
  lane_bundle_t         in_terms;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [AW-1:0] out_data;
  logic                 out_err;

  int n_checks = 0;
  int n_errors = 0;
  bit rand_ready = 0;

  longint exp_data_q[$];
  bit     exp_err_q[$];
  int     beat_sums[$];

  typedef struct {
    logic [8:0] lane;
    int         nbeats;
    bit         last;
    longint     exp_data;
    bit         exp_err;
  } vec_t;

  vec_t vecs[7];

  bitserial_shift_acc #(
    .DATA_WIDTH  (DW),
    .NUM_LANE    (NL),
    .WEIGHT_BITS (WB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_terms  (in_terms),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  function automatic lane_bundle_t all_lanes(input logic [8:0] v);
    lane_bundle_t b;
    for (int l = 0; l < NL; l++) b[l] = v;
    return b;
  endfunction

  function automatic lane_bundle_t one_lane(input int v);
    lane_bundle_t b;
    b    = '0;
    b[0] = 9'(v);
    return b;
  endfunction

  function automatic lane_bundle_t rand_bundle();
    lane_bundle_t b;
    for (int l = 0; l < NL; l++) b[l] = 9'($urandom);
    return b;
  endfunction

  function automatic int lane_sum(input lane_bundle_t b);
    int s = 0;
    for (int l = 0; l < NL; l++) s += int'($signed(b[l]));
    return s;
  endfunction

  // Reference: a closed group of n beat sums is the weighted sum s_k * 2^(n-1-k).
  function automatic void model_beat(input lane_bundle_t b, input logic last);
    int     n;
    longint r;
    beat_sums.push_back(lane_sum(b));
    n = beat_sums.size();
    if (last || n == int'(WB)) begin
      r = 0;
      for (int k = 0; k < n; k++) r += longint'(beat_sums[k]) * (longint'(1) << (n - 1 - k));
      exp_data_q.push_back(r);
      exp_err_q.push_back(!last && n == int'(WB));
      beat_sums.delete();
    end
  endfunction

  always @(negedge clk) begin
    longint d;
    bit     e;
    if (!rst_n) begin
      beat_sums.delete();
      exp_data_q.delete();
      exp_err_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (exp_data_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_result: got %0d, required no result", out_data);
        end else begin
          d = exp_data_q.pop_front();
          e = exp_err_q.pop_front();
          chk("sb_data", longint'(out_data), d);
          chk("sb_err", longint'(out_err), longint'(e));
        end
      end
      if (in_valid && in_ready) model_beat(in_terms, in_last);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Call at posedge+1; returns at posedge+1 after the beat is accepted.
  task automatic send(input lane_bundle_t b, input logic last);
    bit taken = 0;
    in_valid = 1'b1;
    in_terms = b;
    in_last  = last;
    for (int c = 0; c < 200 && !taken; c++) begin
      if (rand_ready) out_ready = ($urandom_range(3) != 0);
      @(negedge clk);
      taken = in_ready;
      @(posedge clk);
      #1;
    end
    if (!taken) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_timeout: in_ready stayed 0, required 1");
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{9'd3,   3, 1'b1,     168, 1'b0};
    vecs[1] = '{9'h080, 7, 1'b1,  130048, 1'b0};
    vecs[2] = '{9'h180, 7, 1'b1, -130048, 1'b0};
    vecs[3] = '{9'd1,   7, 1'b0,    1016, 1'b1};
    vecs[4] = '{9'd1,   1, 1'b1,       8, 1'b0};
    vecs[5] = '{9'd2,   7, 1'b1,    2032, 1'b0};
    vecs[6] = '{9'h1FF, 1, 1'b1,      -8, 1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_terms  = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_out_data", longint'(out_data), 0);
    chk("rst_out_err", longint'(out_err), 0);
    chk("rst_in_ready", longint'(in_ready), 1);
    step();
    rst_n = 1'b1;
    step();

    foreach (vecs[i]) begin
      for (int b = 0; b < vecs[i].nbeats; b++)
        send(all_lanes(vecs[i].lane), vecs[i].last && b == vecs[i].nbeats - 1);
      in_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("vec%0d_lat_early", i), longint'(out_valid), 0);
      @(negedge clk);
      chk($sformatf("vec%0d_lat_valid", i), longint'(out_valid), 1);
      chk($sformatf("vec%0d_data", i), longint'(out_data), vecs[i].exp_data);
      chk($sformatf("vec%0d_err", i), longint'(out_err), longint'(vecs[i].exp_err));
      step();
    end

    // Backpressure: result 24 held, queued single-beat group 16 parked in S1.
    out_ready = 1'b0;
    send(all_lanes(9'd1), 1'b0);
    send(all_lanes(9'd1), 1'b1);
    send(all_lanes(9'd2), 1'b1);
    in_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_in_ready", longint'(in_ready), 0);
      chk("bp_valid", longint'(out_valid), 1);
      chk("bp_data", longint'(out_data), 24);
    end
    step();
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_data", longint'(out_data), 24);
    @(negedge clk);
    chk("bp_next_valid", longint'(out_valid), 1);
    chk("bp_next_data", longint'(out_data), 16);
    @(negedge clk);
    chk("bp_drained", longint'(out_valid), 0);
    step();

    // Back-to-back single-beat groups with mixed signs.
    in_valid = 1'b1;
    in_last  = 1'b1;
    in_terms = one_lane(5);
    @(negedge clk);
    chk("b2b_ready", longint'(in_ready), 1);
    step();
    in_terms = one_lane(-7);
    @(negedge clk);
    chk("b2b_early", longint'(out_valid), 0);
    step();
    in_terms = one_lane(0);
    @(negedge clk);
    chk("b2b_v0", longint'(out_valid), 1);
    chk("b2b_d0", longint'(out_data), 5);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_v1", longint'(out_valid), 1);
    chk("b2b_d1", longint'(out_data), -7);
    @(negedge clk);
    chk("b2b_v2", longint'(out_valid), 1);
    chk("b2b_d2", longint'(out_data), 0);
    @(negedge clk);
    chk("b2b_idle", longint'(out_valid), 0);
    step();

    // Reset mid-group after a forced-close result left out_data/out_err nonzero.
    for (int b = 0; b < 7; b++) send(all_lanes(9'd1), 1'b0);
    send(all_lanes(9'd1), 1'b0);
    send(all_lanes(9'd1), 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_data", longint'(out_data), 1016);
    chk("pre_rst_err", longint'(out_err), 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", longint'(out_valid), 0);
    chk("mid_rst_data", longint'(out_data), 0);
    chk("mid_rst_err", longint'(out_err), 0);
    chk("mid_rst_ready", longint'(in_ready), 1);
    @(negedge clk);
    step();
    rst_n = 1'b1;
    step();
    send(one_lane(9), 1'b1);
    in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_early", longint'(out_valid), 0);
    @(negedge clk);
    chk("post_rst_valid", longint'(out_valid), 1);
    chk("post_rst_data", longint'(out_data), 9);
    chk("post_rst_err", longint'(out_err), 0);
    step();

    // Randomized beats, gaps and downstream stalls against the scoreboard.
    rand_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(4) == 0) begin
        in_valid  = 1'b0;
        in_terms  = rand_bundle();
        in_last   = 1'($urandom);
        out_ready = ($urandom_range(3) != 0);
        step();
      end else begin
        send(rand_bundle(), $urandom_range(5) == 0);
      end
    end
    in_valid   = 1'b0;
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    for (int c = 0; c < 20 && exp_data_q.size() != 0; c++) step();
    chk("drain_empty", longint'(exp_data_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bitserial_shift_acc.md
# bitserial_shift_acc

Bit-serial shift-accumulator that consumes one beat per cycle of NUM_LANE signed, sign-applied partial products, each DATA_WIDTH+1 bits wide, as produced by the per-lane positive/negative select stage. Each beat's lanes are summed in a registered adder tree. The sum is folded into a running accumulator MSB-first (acc = 2*acc + sum) over up to WEIGHT_BITS beats. Each finished dot product is handed downstream through a valid/ready output register.

## Interface
- DATA_WIDTH, 8: activation width. Input terms are DATA_WIDTH+1 bits, two's complement.
- NUM_LANE, 8: lanes per beat; power of two, ≥2.
- WEIGHT_BITS, 7: maximum beats per dot product (weight magnitude bits).
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  beat valid.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- in_terms  in  NUM_LANE×(DATA_WIDTH+1)  signed terms; lane i occupies bits [i*(DATA_WIDTH+1) +: DATA_WIDTH+1].
- in_last  in  1  marks the final (LSB) beat of a dot product.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  ACC_WIDTH  signed dot-product result.
- out_err  out  1  result was force-closed after WEIGHT_BITS beats without in_last.

## Operation
- Widths: SUM_WIDTH = DATA_WIDTH+1+$clog2(NUM_LANE); ACC_WIDTH = SUM_WIDTH+WEIGHT_BITS. All additions are sign-extended. No overflow is possible within WEIGHT_BITS beats.
- enable = !(out_valid && !out_ready); in_ready = enable. Every register below updates only when enable is high.
- Stage 1 (S1): on handshake, s1_sum = signed sum of all lanes. Also register s1_valid=1, s1_last, and s1_beat (beat index). With no handshake, s1_valid=0.
- Beat counter: counts accepted beats of the current group. The first beat is index 0; the counter resets to 0 after a closing beat.
- Closing beat: in_last=1, or beat index == WEIGHT_BITS-1. A forced close (index == WEIGHT_BITS-1 with in_last=0) sets an error flag that travels with that group.
- Stage 2 (ACC): when s1_valid:
  - if s1_beat==0, acc = s1_sum; otherwise acc = (acc<<1) + s1_sum.
  - If the beat is closing, the new acc value is loaded into out_data with out_valid=1 and out_err=flag, and acc is free for the next group.
- Output: out_valid clears on (out_valid && out_ready) when no new result loads in the same cycle. A simultaneous handshake and new result gives back-to-back valid with the new data.
- Single-beat groups are legal (result = sum). Idle cycles between beats of a group are legal and do not disturb acc.
- in_last sampled together with a forced close: the result is not an error (out_err=0).

## Timing
- Reset values: out_valid=0, out_data=0, out_err=0, acc=0, s1_valid=0, beat counter=0. in_ready=1 out of reset.
- Reset mid-group discards all partial state. The first beat after reset starts a new group.
- Latency: the closing beat accepted at cycle t gives out_valid=1 at t+2, provided enable stayed high.
- Throughput: one beat per cycle. A group of N beats can be followed by the next group with no bubble.
- Backpressure: while out_valid && !out_ready, in_ready=0 and S1, ACC and the counter hold.
- in_terms/in_last are don't-care when in_valid=0. out_data/out_err are stable while out_valid && !out_ready.

## Structure
- Shared package bitsim_pkg:
  - width helper functions for SUM_WIDTH and ACC_WIDTH;
  - a packed-array typedef for the lane bundle.
- Sub-module signed_adder_tree (parameters NUM_LANE, IN_WIDTH): combinational and fully sign-extended. The top registers its output as S1.
- The FSM is implicit in the beat counter plus the out_valid register. No separate state enum.

## Test plan
- Defaults. All lanes +3, three beats with in_last on the third → out_data=168, out_err=0, out_valid at closing+2.
- All lanes +128 (9'h080), seven beats, in_last on the seventh → out_data=130048. All lanes −128 → −130048.
- Eight beats of all +1 with no in_last → first result after beat 7 = 1016 (8×127) with out_err=1. Beat 8 alone forms a new group: out_data=8, out_err=0.
- Hold out_ready=0 for 5 cycles with a result pending → in_ready=0 and out_data stable. Release: that result is taken, the queued group completes, and values are unchanged.
- Back-to-back single-beat groups with mixed signs (lane sums 5, −7, 0), out_ready=1 → results 5, −7, 0 on consecutive cycles.
- Deassert rst_n after beat 2 of a group → outputs return to reset values immediately. Next group: one beat of sum 9 with in_last → 9.
